// File: rtl/kart_net_pkg.sv
// kart_net_pkg
//   Shared definitions for the kart network receive path: bit positions of
//   the fields inside a 44-bit racer-state word and the packed racer state
//   record that the per-opponent channels store.
package kart_net_pkg;

    localparam int WORD_W     = 44;

    localparam int X_MSB      = 43;
    localparam int X_LSB      = 33;
    localparam int Y_MSB      = 31;
    localparam int Y_LSB      = 21;
    localparam int DIR_MSB    = 19;
    localparam int DIR_LSB    = 11;
    localparam int ID_MSB     = 10;
    localparam int ID_LSB     = 8;
    localparam int GAME_MSB   = 7;
    localparam int GAME_LSB   = 5;
    localparam int RSTREQ_BIT = 3;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [8:0]  dir;
        logic [2:0]  game;
    } racer_state_t;

endpackage

// File: rtl/opp_channel.sv
// opp_channel
//   State for one opponent: stored racer fields, change detection, link
//   staleness timer and remote-reset confirmation counter.
// Ports
//   clk_in     clock
//   rst_in_n   asynchronous active-low reset
//   accept     a word for this channel is present this cycle
//   rst_bit    reset_req bit of the presented word
//   state_in   racer fields of the presented word
//   state_q    stored racer fields
//   valid      at least one word accepted since reset
//   stale      no word accepted for STALE_CYC cycles
//   chg        (combinational) the presented word will change the stored state
//   rst_hit    (combinational) the presented word completes a reset confirmation
module opp_channel
    import kart_net_pkg::*;
#(
    parameter int STALE_CYC   = 2_500_000,
    parameter int RST_CONFIRM = 3
) (
    input  logic         clk_in,
    input  logic         rst_in_n,
    input  logic         accept,
    input  logic         rst_bit,
    input  racer_state_t state_in,
    output racer_state_t state_q,
    output logic         valid,
    output logic         stale,
    output logic         chg,
    output logic         rst_hit
);

    localparam int TW = (STALE_CYC > 2) ? $clog2(STALE_CYC) : 1;
    localparam int RW = $clog2(RST_CONFIRM + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(STALE_CYC - 1);
    localparam logic [RW-1:0] RC_MAX    = RW'(RST_CONFIRM);

    racer_state_t  state_reg;
    logic          valid_reg;
    logic          stale_reg;
    logic [TW-1:0] timer_reg;
    logic [RW-1:0] rc_reg;
    logic [RW-1:0] rc_inc;

    // rc_reg never holds RC_MAX (it clears on reaching it), so the increment
    // cannot wrap.
    assign rc_inc = rc_reg + 1'b1;

    always_comb begin
        chg     = accept && (!valid_reg || (state_in != state_reg));
        rst_hit = accept && rst_bit && (rc_inc == RC_MAX);
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_reg <= '0;
            valid_reg <= 1'b0;
            stale_reg <= 1'b0;
            timer_reg <= '0;
            rc_reg    <= '0;
        end else begin
            if (accept) begin
                // A word arriving on the timeout edge takes priority.
                timer_reg <= '0;
                stale_reg <= 1'b0;
                valid_reg <= 1'b1;
                if (chg) begin
                    state_reg <= state_in;
                end
                if (!rst_bit || rst_hit) begin
                    rc_reg <= '0;
                end else begin
                    rc_reg <= rc_inc;
                end
            end else if (valid_reg && !stale_reg) begin
                if (timer_reg == TIMER_MAX) begin
                    stale_reg <= 1'b1;
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end
        end
    end

    assign state_q = state_reg;
    assign valid   = valid_reg;
    assign stale   = stale_reg;

endmodule

// File: rtl/opponent_state_rx.sv
// opponent_state_rx
//   Splits decoded racer-state words from the receive block into NUM_OPP
//   per-opponent channels, filters zero words and duplicates, flags stale
//   links and confirms remote reset requests.
// Ports
//   clk_in       clock (eth_refclk domain)
//   rst_in_n     asynchronous active-low reset
//   axiov_in     word valid qualifier, one cycle per word
//   axiod_in     44-bit racer-state word
//   opp_x_o      per-channel x, channel k at [11k+10:11k]
//   opp_y_o      per-channel y
//   opp_dir_o    per-channel direction
//   opp_game_o   per-channel game status
//   opp_valid_o  channel has received a word since reset
//   opp_stale_o  channel timed out
//   upd_o        one-cycle strobe: a channel's state changed
//   upd_id_o     channel of the last upd_o strobe
//   rst_req_o    one-cycle pulse: confirmed remote reset request
//   drop_cnt_o   saturating count of words with an out-of-range id
module opponent_state_rx
    import kart_net_pkg::*;
#(
    parameter int NUM_OPP     = 2,
    parameter int STALE_CYC   = 2_500_000,
    parameter int RST_CONFIRM = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_in_n,
    input  logic                   axiov_in,
    input  logic [WORD_W-1:0]      axiod_in,
    output logic [NUM_OPP*11-1:0]  opp_x_o,
    output logic [NUM_OPP*11-1:0]  opp_y_o,
    output logic [NUM_OPP*9-1:0]   opp_dir_o,
    output logic [NUM_OPP*3-1:0]   opp_game_o,
    output logic [NUM_OPP-1:0]     opp_valid_o,
    output logic [NUM_OPP-1:0]     opp_stale_o,
    output logic                   upd_o,
    output logic [2:0]             upd_id_o,
    output logic                   rst_req_o,
    output logic [15:0]            drop_cnt_o
);

    racer_state_t word_state;
    logic [2:0]   word_id;
    logic         word_live;
    logic         id_ok;
    logic         unused_bits;

    assign word_state.x    = axiod_in[X_MSB:X_LSB];
    assign word_state.y    = axiod_in[Y_MSB:Y_LSB];
    assign word_state.dir  = axiod_in[DIR_MSB:DIR_LSB];
    assign word_state.game = axiod_in[GAME_MSB:GAME_LSB];
    assign word_id         = axiod_in[ID_MSB:ID_LSB];
    assign unused_bits     = ^{axiod_in[32], axiod_in[20], axiod_in[4], axiod_in[2:0]};

    // All-zero words are idle fill from the receive path, not traffic.
    assign word_live = axiov_in && (axiod_in != '0);
    assign id_ok     = ({1'b0, word_id} < 4'(NUM_OPP));

    logic [NUM_OPP-1:0] accept_vec;
    logic [NUM_OPP-1:0] valid_vec;
    logic [NUM_OPP-1:0] stale_vec;
    logic [NUM_OPP-1:0] chg_vec;
    logic [NUM_OPP-1:0] hit_vec;
    racer_state_t       st_q [NUM_OPP];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPP; gi++) begin : g_chan
            assign accept_vec[gi] = word_live && id_ok && (word_id == 3'(gi));

            opp_channel #(
                .STALE_CYC   (STALE_CYC),
                .RST_CONFIRM (RST_CONFIRM)
            ) u_chan (
                .clk_in   (clk_in),
                .rst_in_n (rst_in_n),
                .accept   (accept_vec[gi]),
                .rst_bit  (axiod_in[RSTREQ_BIT]),
                .state_in (word_state),
                .state_q  (st_q[gi]),
                .valid    (valid_vec[gi]),
                .stale    (stale_vec[gi]),
                .chg      (chg_vec[gi]),
                .rst_hit  (hit_vec[gi])
            );

            assign opp_x_o[11*gi +: 11]  = st_q[gi].x;
            assign opp_y_o[11*gi +: 11]  = st_q[gi].y;
            assign opp_dir_o[9*gi +: 9]  = st_q[gi].dir;
            assign opp_game_o[3*gi +: 3] = st_q[gi].game;
        end
    endgenerate

    logic        upd_reg;
    logic [2:0]  upd_id_reg;
    logic        rst_req_reg;
    logic [15:0] drop_cnt_reg;

    // Only one word arrives per cycle, so at most one chg bit is set; the
    // OR-reductions also merge simultaneous confirmations into one pulse.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            upd_reg      <= 1'b0;
            upd_id_reg   <= '0;
            rst_req_reg  <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            upd_reg     <= |chg_vec;
            rst_req_reg <= |hit_vec;
            if (|chg_vec) begin
                upd_id_reg <= word_id;
            end
            if (word_live && !id_ok && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign opp_valid_o = valid_vec;
    assign opp_stale_o = stale_vec;
    assign upd_o       = upd_reg;
    assign upd_id_o    = upd_id_reg;
    assign rst_req_o   = rst_req_reg;
    assign drop_cnt_o  = drop_cnt_reg;

endmodule

// File: tb/tb_opponent_state_rx.sv
module tb_opponent_state_rx;
    import kart_net_pkg::*;

    localparam int NUM_OPP     = 2;
    localparam int STALE_CYC   = 16;
    localparam int RST_CONFIRM = 3;

    logic                  clk_in = 1'b0;
    logic                  rst_in_n;
    logic                  axiov_in;
    logic [43:0]           axiod_in;
    logic [NUM_OPP*11-1:0] opp_x_o;
    logic [NUM_OPP*11-1:0] opp_y_o;
    logic [NUM_OPP*9-1:0]  opp_dir_o;
    logic [NUM_OPP*3-1:0]  opp_game_o;
    logic [NUM_OPP-1:0]    opp_valid_o;
    logic [NUM_OPP-1:0]    opp_stale_o;
    logic                  upd_o;
    logic [2:0]            upd_id_o;
    logic                  rst_req_o;
    logic [15:0]           drop_cnt_o;

    opponent_state_rx #(
        .NUM_OPP     (NUM_OPP),
        .STALE_CYC   (STALE_CYC),
        .RST_CONFIRM (RST_CONFIRM)
    ) dut (
        .clk_in      (clk_in),
        .rst_in_n    (rst_in_n),
        .axiov_in    (axiov_in),
        .axiod_in    (axiod_in),
        .opp_x_o     (opp_x_o),
        .opp_y_o     (opp_y_o),
        .opp_dir_o   (opp_dir_o),
        .opp_game_o  (opp_game_o),
        .opp_valid_o (opp_valid_o),
        .opp_stale_o (opp_stale_o),
        .upd_o       (upd_o),
        .upd_id_o    (upd_id_o),
        .rst_req_o   (rst_req_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- behavioural reference model ----------------
    bit           m_valid [NUM_OPP];
    int           m_since [NUM_OPP];   // edges since last accepted word
    int           m_rc    [NUM_OPP];   // consecutive reset_req words
    int           m_x [NUM_OPP], m_y [NUM_OPP], m_dir [NUM_OPP], m_game [NUM_OPP];
    int           m_drop;
    bit           m_upd;
    int           m_upd_id;
    bit           m_rst;

    function automatic logic [43:0] mk(input int x, input int y, input int dir,
                                       input int id, input int game, input int rr);
        logic [43:0] w;
        w = '0;
        w[43:33] = 11'(x);
        w[31:21] = 11'(y);
        w[19:11] = 9'(dir);
        w[10:8]  = 3'(id);
        w[7:5]   = 3'(game);
        w[3]     = rr[0];
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_OPP; c++) begin
            m_valid[c] = 0; m_since[c] = 0; m_rc[c] = 0;
            m_x[c] = 0; m_y[c] = 0; m_dir[c] = 0; m_game[c] = 0;
        end
        m_drop = 0; m_upd = 0; m_upd_id = 0; m_rst = 0;
    endtask

    task automatic model_step(input bit v, input logic [43:0] w);
        int  id, x, y, dir, game;
        bit  acc;
        id   = int'(w[10:8]);
        x    = int'(w[43:33]);
        y    = int'(w[31:21]);
        dir  = int'(w[19:11]);
        game = int'(w[7:5]);
        acc  = 0;
        m_upd = 0;
        m_rst = 0;
        if (v && w != 44'd0) begin
            if (id >= NUM_OPP) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                acc = 1;
            end
        end
        for (int c = 0; c < NUM_OPP; c++) begin
            if (!(acc && c == id) && m_valid[c] && m_since[c] < 1000000) m_since[c]++;
        end
        if (acc) begin
            if (!m_valid[id] || m_x[id] != x || m_y[id] != y || m_dir[id] != dir || m_game[id] != game) begin
                m_x[id] = x; m_y[id] = y; m_dir[id] = dir; m_game[id] = game;
                m_upd = 1;
                m_upd_id = id;
            end
            m_valid[id] = 1;
            m_since[id] = 0;
            if (w[3]) begin
                m_rc[id]++;
                if (m_rc[id] == RST_CONFIRM) begin
                    m_rst = 1;
                    m_rc[id] = 0;
                end
            end else begin
                m_rc[id] = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NUM_OPP; c++) begin
            chk($sformatf("%s x[%0d]", tag, c),     64'(opp_x_o[11*c +: 11]),  64'(m_x[c]));
            chk($sformatf("%s y[%0d]", tag, c),     64'(opp_y_o[11*c +: 11]),  64'(m_y[c]));
            chk($sformatf("%s dir[%0d]", tag, c),   64'(opp_dir_o[9*c +: 9]),  64'(m_dir[c]));
            chk($sformatf("%s game[%0d]", tag, c),  64'(opp_game_o[3*c +: 3]), 64'(m_game[c]));
            chk($sformatf("%s valid[%0d]", tag, c), 64'(opp_valid_o[c]),       64'(m_valid[c]));
            chk($sformatf("%s stale[%0d]", tag, c), 64'(opp_stale_o[c]),
                64'(m_valid[c] && m_since[c] >= STALE_CYC));
        end
        chk({tag, " upd"},     64'(upd_o),      64'(m_upd));
        chk({tag, " upd_id"},  64'(upd_id_o),   64'(m_upd_id));
        chk({tag, " rst_req"}, 64'(rst_req_o),  64'(m_rst));
        chk({tag, " drop"},    64'(drop_cnt_o), 64'(m_drop));
    endtask

    // Drive one cycle of input, let the edge consume it, then compare.
    task automatic step(input bit v, input logic [43:0] w, input string tag);
        axiov_in = v;
        axiod_in = w;
        @(posedge clk_in);
        #1;
        model_step(v, w);
        $display("txn %s v=%0d w=%011h upd=%0d id=%0d rst=%0d drop=%0d stale=%b",
                 tag, v, w, upd_o, upd_id_o, rst_req_o, drop_cnt_o, opp_stale_o);
        check_all(tag);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          v;
        logic [43:0] w;
        bit          upd;
        logic [2:0]  upd_id;
        bit          rst;
        logic [15:0] drop;
        logic [10:0] x0;
        logic [1:0]  valid;
    } vec_t;

    vec_t tbl [18];

    logic [43:0] w_a, w_b;

    initial begin
        rst_in_n = 1'b0;
        axiov_in = 1'b0;
        axiod_in = '0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check_all("reset_hold");
        rst_in_n = 1'b1;

        //            v  word                         upd id  rst drop x0   valid
        tbl[0]  = '{1, mk(100,200,45,0,1,0),      1, 0, 0, 0, 100, 2'b01};
        tbl[1]  = '{1, mk(100,200,45,0,1,0),      0, 0, 0, 0, 100, 2'b01};
        tbl[2]  = '{1, mk(100,200,45,0,1,0),      0, 0, 0, 0, 100, 2'b01};
        tbl[3]  = '{1, mk(100,200,45,0,1,0),      0, 0, 0, 0, 100, 2'b01};
        tbl[4]  = '{1, mk(100,200,45,0,1,0),      0, 0, 0, 0, 100, 2'b01};
        tbl[5]  = '{1, mk(100,200,45,0,1,0),      0, 0, 0, 0, 100, 2'b01};
        tbl[6]  = '{1, mk(101,200,45,0,1,0),      1, 0, 0, 0, 101, 2'b01};
        tbl[7]  = '{1, mk(1,2,3,5,0,0),           0, 0, 0, 1, 101, 2'b01};
        tbl[8]  = '{1, 44'd0,                     0, 0, 0, 1, 101, 2'b01};
        tbl[9]  = '{0, mk(5,5,5,0,0,0),           0, 0, 0, 1, 101, 2'b01};
        tbl[10] = '{1, mk(7,8,9,1,2,0),           1, 1, 0, 1, 101, 2'b11};
        tbl[11] = '{1, mk(101,200,45,0,1,1),      0, 1, 0, 1, 101, 2'b11};
        tbl[12] = '{1, mk(101,200,45,0,1,1),      0, 1, 0, 1, 101, 2'b11};
        tbl[13] = '{1, mk(101,200,45,0,1,0),      0, 1, 0, 1, 101, 2'b11};
        tbl[14] = '{1, mk(101,200,45,0,1,1),      0, 1, 0, 1, 101, 2'b11};
        tbl[15] = '{1, mk(101,200,45,0,1,1),      0, 1, 0, 1, 101, 2'b11};
        tbl[16] = '{1, mk(101,200,45,0,1,1),      0, 1, 1, 1, 101, 2'b11};
        tbl[17] = '{0, 44'd0,                     0, 1, 0, 1, 101, 2'b11};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].w, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d upd", i),    64'(upd_o),           64'(tbl[i].upd));
            chk($sformatf("tbl%0d upd_id", i), 64'(upd_id_o),        64'(tbl[i].upd_id));
            chk($sformatf("tbl%0d rst", i),    64'(rst_req_o),       64'(tbl[i].rst));
            chk($sformatf("tbl%0d drop", i),   64'(drop_cnt_o),      64'(tbl[i].drop));
            chk($sformatf("tbl%0d x0", i),     64'(opp_x_o[10:0]),   64'(tbl[i].x0));
            chk($sformatf("tbl%0d valid", i),  64'(opp_valid_o),     64'(tbl[i].valid));
        end

        // ---------------- stale timing on channel 1 ----------------
        w_b = mk(300,400,100,1,3,0);
        step(1, w_b, "stale_arm");
        chk("stale_arm upd", 64'(upd_o), 64'd1);
        for (int k = 1; k <= 15; k++) begin
            step(0, 44'd0, $sformatf("stale_wait%0d", k));
            chk($sformatf("stale_wait%0d", k), 64'(opp_stale_o[1]), 64'd0);
        end
        // Word on the timeout edge wins.
        step(1, w_b, "stale_race");
        chk("stale_race stale1", 64'(opp_stale_o[1]), 64'd0);
        chk("stale_race upd",    64'(upd_o),          64'd0);
        for (int k = 1; k <= 17; k++) begin
            step(0, 44'd0, $sformatf("stale_run%0d", k));
            chk($sformatf("stale_run%0d", k), 64'(opp_stale_o[1]), 64'(k >= STALE_CYC));
        end
        chk("stale_keep x1", 64'(opp_x_o[21:11]), 64'd300);
        step(1, w_b, "stale_clear");
        chk("stale_clear stale1", 64'(opp_stale_o[1]), 64'd0);
        chk("stale_clear upd",    64'(upd_o),          64'd0);

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 600; i++) begin
            bit          v;
            logic [43:0] w;
            int          pct;
            pct = (i < 300) ? 75 : 8;
            v = ($urandom_range(0, 99) < pct);
            if ($urandom_range(0, 9) == 0) begin
                w = 44'd0;
            end else begin
                w = mk($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 3), $urandom_range(0, 1),
                       ($urandom_range(0, 9) < 7) ? 1 : 0);
                w[2:0] = 3'($urandom_range(0, 7));   // ignored bits
            end
            step(v, w, $sformatf("rnd%0d", i));
        end

        // ---------------- asynchronous reset mid-burst ----------------
        w_a = mk(55,66,77,0,2,1);
        step(1, w_a, "burst0");
        step(1, mk(56,66,77,1,2,1), "burst1");
        axiov_in = 1'b1;
        axiod_in = mk(57,66,77,0,2,1);
        #3;
        rst_in_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst valid", 64'(opp_valid_o), 64'd0);
        chk("async_rst drop",  64'(drop_cnt_o),  64'd0);
        axiov_in = 1'b0;
        axiod_in = '0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        step(1, w_a, "post_rst");
        chk("post_rst upd",    64'(upd_o),         64'd1);
        chk("post_rst upd_id", 64'(upd_id_o),      64'd0);
        chk("post_rst x0",     64'(opp_x_o[10:0]), 64'd55);
        step(1, w_a, "post_rst2");
        step(1, w_a, "post_rst3");
        chk("post_rst confirm", 64'(rst_req_o), 64'd1);
        step(0, 44'd0, "tail");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
